// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman datapath: exponentiator FSM states
// and the default operand width.
package dh_pkg;

    localparam int DH_WIDTH = 100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        REDUCE = 3'd2,
        MUL    = 3'd3,
        SQR    = 3'd4,
        FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/mod_mult_seq.sv
// Bit-serial interleaved modular multiplier: p = a*b mod m, MSB-first over b.
// One load cycle followed by WIDTH iterations; done pulses with p valid.
module mod_mult_seq
    import dh_pkg::*;
#(
    parameter int WIDTH = DH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] t_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] p_reg;

    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] t_dbl;
    logic [WIDTH+1:0] t_sub1;
    logic [WIDTH+1:0] t_sub2;

    // With t < m and a < m, 2t + a < 3m, so two conditional subtracts suffice.
    always_comb begin
        m_ext  = {2'b00, m_reg};
        t_dbl  = (t_reg << 1) + (b_reg[WIDTH-1] ? {2'b00, a_reg} : '0);
        t_sub1 = (t_dbl >= m_ext) ? t_dbl - m_ext : t_dbl;
        t_sub2 = (t_sub1 >= m_ext) ? t_sub1 - m_ext : t_sub1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            m_reg    <= '0;
            t_reg    <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            p_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                a_reg    <= a;
                b_reg    <= b;
                m_reg    <= m;
                t_reg    <= '0;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                t_reg   <= t_sub2;
                b_reg   <= b_reg << 1;
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    p_reg    <= t_sub2[WIDTH-1:0];
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign p    = p_reg;

endmodule

// File: rtl/modular_exp_seq.sv
// Right-to-left square-and-multiply exponentiator: result = base^exponent mod modulus.
// One shared modular multiplier; the next product is launched on the edge the previous one lands.
module modular_exp_seq
    import dh_pkg::*;
#(
    parameter int WIDTH     = DH_WIDTH,
    parameter int EXP_WIDTH = WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 ready,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    state_t               state_reg;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [WIDTH-1:0]     base_reg;
    logic [WIDTH-1:0]     m_reg;
    logic [WIDTH-1:0]     r_reg;
    logic [WIDTH-1:0]     acc_reg;
    logic                 err_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic                 error_reg;
    logic [WIDTH-1:0]     result_reg;

    logic                 mm_start;
    logic [WIDTH-1:0]     mm_a;
    logic [WIDTH-1:0]     mm_b;
    logic                 mm_busy;
    logic                 mm_done;
    logic [WIDTH-1:0]     mm_p;
    logic [EXP_WIDTH-1:0] e_shift;

    // Operand muxing takes a fresh product straight from the multiplier so that
    // back-to-back products need no extra hand-off cycle.
    always_comb begin
        mm_start = 1'b0;
        mm_a     = acc_reg;
        mm_b     = r_reg;
        e_shift  = e_reg >> 1;
        case (state_reg)
            CHECK: begin
                if (m_reg != '0 && e_reg != '0) begin
                    mm_start = 1'b1;
                    mm_a     = WIDTH'(1);
                    mm_b     = base_reg;
                end
            end
            REDUCE, SQR: begin
                if (mm_done) begin
                    mm_start = 1'b1;
                    mm_a     = mm_p;
                    mm_b     = e_reg[0] ? r_reg : mm_p;
                end
            end
            MUL: begin
                if (mm_done && e_shift != '0) begin
                    mm_start = 1'b1;
                    mm_a     = acc_reg;
                    mm_b     = acc_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            e_reg      <= '0;
            base_reg   <= '0;
            m_reg      <= '0;
            r_reg      <= '0;
            acc_reg    <= '0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && ready_reg) begin
                        base_reg  <= base;
                        e_reg     <= exponent;
                        m_reg     <= modulus;
                        ready_reg <= 1'b0;
                        error_reg <= 1'b0;
                        state_reg <= CHECK;
                    end
                end
                CHECK: begin
                    // r starts at 1 mod m, which is 0 for m==1 (and for the m==0 error case).
                    r_reg   <= (m_reg == '0 || m_reg == WIDTH'(1)) ? '0 : WIDTH'(1);
                    err_reg <= (m_reg == '0);
                    if (m_reg == '0 || e_reg == '0) begin
                        state_reg <= FIN;
                    end else begin
                        state_reg <= REDUCE;
                    end
                end
                REDUCE, SQR: begin
                    if (mm_done) begin
                        acc_reg <= mm_p;
                        if (e_reg[0]) begin
                            state_reg <= MUL;
                        end else begin
                            e_reg     <= e_shift;
                            state_reg <= SQR;
                        end
                    end
                end
                MUL: begin
                    if (mm_done) begin
                        r_reg     <= mm_p;
                        e_reg     <= e_shift;
                        state_reg <= (e_shift == '0) ? FIN : SQR;
                    end
                end
                FIN: begin
                    result_reg <= r_reg;
                    error_reg  <= err_reg;
                    done_reg   <= 1'b1;
                    ready_reg  <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    mod_mult_seq #(
        .WIDTH(WIDTH)
    ) u_mod_mult (
        .clk  (clk),
        .rst  (rst),
        .start(mm_start),
        .a    (mm_a),
        .b    (mm_b),
        .m    (m_reg),
        .busy (mm_busy),
        .done (mm_done),
        .p    (mm_p)
    );

    assign ready  = ready_reg;
    assign done   = done_reg;
    assign error  = error_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_modular_exp_seq.sv
// Directed-vector bench for modular_exp_seq at WIDTH=16, plus a WIDTH=100 smoke run
// against a native-arithmetic reference.
module tb_modular_exp_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 1'b0;
    logic [15:0] base16 = '0;
    logic [16:0] exp16 = '0;
    logic [15:0] mod16 = '0;
    logic        ready16, done16, error16;
    logic [15:0] result16;

    logic         start100 = 1'b0;
    logic [99:0]  base100 = '0;
    logic [100:0] exp100 = '0;
    logic [99:0]  mod100 = '0;
    logic         ready100, done100, error100;
    logic [99:0]  result100;

    modular_exp_seq #(.WIDTH(16), .EXP_WIDTH(17)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .base(base16), .exponent(exp16),
        .modulus(mod16), .ready(ready16), .done(done16), .error(error16), .result(result16)
    );

    modular_exp_seq #(.WIDTH(100), .EXP_WIDTH(101)) dut100 (
        .clk(clk), .rst(rst), .start(start100), .base(base100), .exponent(exp100),
        .modulus(mod100), .ready(ready100), .done(done100), .error(error100), .result(result100)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] b;
        logic [16:0] e;
        logic [15:0] m;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [99:0] got, input logic [99:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Runs one job; intr_at>0 pulses a conflicting start at that cycle of the job.
    task automatic run_job(input bit big, input logic [99:0] b, input logic [100:0] e,
                           input logic [99:0] m, input int intr_at,
                           output logic [99:0] res, output logic err, output int lat);
        bit got;
        @(negedge clk);
        if (big) begin
            base100 = b; exp100 = e; mod100 = m; start100 = 1'b1;
        end else begin
            base16 = b[15:0]; exp16 = e[16:0]; mod16 = m[15:0]; start16 = 1'b1;
        end
        @(posedge clk);
        #1;
        start16 = 1'b0; start100 = 1'b0;
        base16 = 16'hbeef; exp16 = 17'h1abcd; mod16 = 16'h0003;
        base100 = '1; exp100 = '1; mod100 = 100'd5;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (intr_at > 0 && lat == intr_at) begin
                base16 = 16'd2; exp16 = 17'd3; mod16 = 16'd5; start16 = 1'b1;
            end else begin
                start16 = 1'b0;
            end
            if (big ? done100 : done16) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: done not seen within %0d cycles", lat);
            res = '0;
            err = 1'b0;
        end else begin
            res = big ? result100 : {84'd0, result16};
            err = big ? error100 : error16;
            check("ready_with_done", {99'd0, big ? ready100 : ready16}, 100'd1);
            @(negedge clk);
            check("done_one_cycle", {99'd0, big ? done100 : done16}, 100'd0);
        end
        $display("job w=%0d base=%0d exp=%0d mod=%0d -> result=%0d error=%0d latency=%0d",
                 big ? 100 : 16, b, e, m, res, err, lat);
    endtask

    function automatic logic [99:0] ref_pow(input logic [99:0] b, input logic [100:0] e,
                                            input logic [99:0] m);
        logic [199:0] r, x, mm;
        mm = {100'd0, m};
        r  = 200'd1 % mm;
        x  = {100'd0, b} % mm;
        for (int i = 0; i < 101; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[99:0];
    endfunction

    function automatic int ref_lat(input logic [100:0] e, input int w);
        int bl;
        bl = 0;
        for (int i = 0; i < 101; i++) if (e[i]) bl = i + 1;
        return 2 + (1 + $countones(e) + bl - 1) * (w + 1);
    endfunction

    initial begin
        vec_t        vecs[12];
        logic [99:0] res;
        logic        err;
        int          lat;
        bit          seen;

        vecs[0]  = '{16'd4,     17'd13,     16'd497,   16'd445,   1'b0, 121};
        vecs[1]  = '{16'd3,     17'd0,      16'd7,     16'd1,     1'b0, 2};
        vecs[2]  = '{16'd2,     17'd10,     16'd1,     16'd0,     1'b0, 104};
        vecs[3]  = '{16'd1000,  17'd1,      16'd7,     16'd6,     1'b0, 36};
        vecs[4]  = '{16'd5,     17'd3,      16'd0,     16'd0,     1'b1, 2};
        vecs[5]  = '{16'd3,     17'd5,      16'd13,    16'd9,     1'b0, 87};
        vecs[6]  = '{16'd0,     17'd5,      16'd11,    16'd0,     1'b0, 87};
        vecs[7]  = '{16'd2,     17'd16,     16'd65535, 16'd1,     1'b0, 104};
        vecs[8]  = '{16'd7,     17'd2,      16'd10,    16'd9,     1'b0, 53};
        vecs[9]  = '{16'd65535, 17'd2,      16'd65521, 16'd196,   1'b0, 53};
        vecs[10] = '{16'd12,    17'h1ffff,  16'd13,    16'd12,    1'b0, 580};
        vecs[11] = '{16'd9,     17'd0,      16'd1,     16'd0,     1'b0, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {99'd0, ready16}, 100'd1);
        check("reset_done", {99'd0, done16}, 100'd0);
        check("reset_error", {99'd0, error16}, 100'd0);
        check("reset_result", {84'd0, result16}, 100'd0);
        check("reset_result_w100", result100, 100'd0);

        for (int i = 0; i < 12; i++) begin
            run_job(1'b0, {84'd0, vecs[i].b}, {84'd0, vecs[i].e}, {84'd0, vecs[i].m}, 0,
                    res, err, lat);
            check($sformatf("vec%0d_result", i), res, {84'd0, vecs[i].res});
            check($sformatf("vec%0d_error", i), {99'd0, err}, {99'd0, vecs[i].err});
            check($sformatf("vec%0d_latency", i), 100'(lat), 100'(vecs[i].lat));
        end

        // Conflicting start mid-job must be ignored.
        run_job(1'b0, 100'd4, 101'd13, 100'd497, 30, res, err, lat);
        check("intr_result", res, 100'd445);
        check("intr_latency", 100'(lat), 100'd121);

        // Reset at cycle 40 aborts the job with no done pulse.
        @(negedge clk);
        base16 = 16'd4; exp16 = 17'd13; mod16 = 16'd497; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {99'd0, ready16}, 100'd1);
        seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done16) seen = 1'b1;
        end
        check("abort_no_done", {99'd0, seen}, 100'd0);
        $display("job w=16 base=4 exp=13 mod=497 aborted by reset at cycle 40");
        run_job(1'b0, 100'd5, 101'd117, 100'd19, 0, res, err, lat);
        check("restart_result", res, 100'd1);
        check("restart_latency", 100'(lat), 100'd206);

        // WIDTH=100 smoke run against the reference model.
        for (int j = 0; j < 10; j++) begin
            logic [127:0] rb, rm;
            logic [99:0]  b, m;
            logic [100:0] e;
            rb = {$urandom, $urandom, $urandom, $urandom};
            rm = {$urandom, $urandom, $urandom, $urandom};
            b  = rb[99:0];
            m  = (j == 0) ? 100'd1 : rm[99:0];
            if (m == '0) m = 100'd97;
            e  = 101'($urandom_range(1, 1023));
            run_job(1'b1, b, e, m, 0, res, err, lat);
            check($sformatf("w100_job%0d_result", j), res, ref_pow(b, e, m));
            check($sformatf("w100_job%0d_error", j), {99'd0, err}, 100'd0);
            check($sformatf("w100_job%0d_latency", j), 100'(lat), 100'(ref_lat(e, 100)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
